// File: rtl/alu.sv
// alu: registered add/sub/mul/and on unsigned operands with zero and borrow flags
module alu #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         alu_sel,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               neg
);
  logic [2*WIDTH-1:0] a, b, res;
  assign a = (2*WIDTH)'(A);
  assign b = (2*WIDTH)'(B);
  // operands are zero-extended so ADD and MUL never wrap and SUB wraps mod 2^(2*WIDTH)
  always_comb res = alu_sel == 2'd0 ? a + b : alu_sel == 2'd1 ? a - b : alu_sel == 2'd2 ? a * b : a & b;
  // output registers; data and flags hold when no op is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= res;
        zero   <= res == '0;
        neg    <= alu_sel == 2'd1 && A < B;
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed checks of alu against an arithmetic reference model
module tb_alu;
  localparam int W = 6;
  localparam int MASK = (1 << (2 * W)) - 1;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0] sel = '0;
  logic out_valid, zero, neg;
  logic [2*W-1:0] result;
  int cnt = 0, errs = 0;
  bit chk = 0;
  logic m_valid, m_zero, m_neg;
  int m_res;

  alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .alu_sel(sel), .out_valid(out_valid), .result(result), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  function automatic int model_res(int x, int y, int s);
    if (s == 0) return x + y;
    if (s == 1) return (x - y) & MASK;
    if (s == 2) return x * y;
    return x & y;
  endfunction

  // reference model: one-cycle latency, flags held when idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_res <= 0; m_zero <= 0; m_neg <= 0;
    end else if (in_valid) begin
      m_valid <= 1;
      m_res <= model_res(a, b, sel);
      m_zero <= model_res(a, b, sel) == 0;
      m_neg <= sel == 1 && a < b;
    end else m_valid <= 0;
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    cnt++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) if (chk) begin
    check("ov", {31'd0, out_valid}, {31'd0, m_valid});
    check("res", {20'd0, result}, m_res);
    check("zero", {31'd0, zero}, {31'd0, m_zero});
    check("neg", {31'd0, neg}, {31'd0, m_neg});
  end

  task automatic op(input int x, input int y, input int s, input int er, input int ez, input int en);
    @(negedge clk);
    a = W'(x); b = W'(y); sel = 2'(s); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check("lit_ov", {31'd0, out_valid}, 1);
    check("lit_res", {20'd0, result}, er);
    check("lit_zero", {31'd0, zero}, ez);
    check("lit_neg", {31'd0, neg}, en);
    check("lit_model", m_res, er);
  endtask

  initial begin
    #12 rst_n = 1;
    @(negedge clk);
    check("rst_ov", {31'd0, out_valid}, 0);
    check("rst_res", {20'd0, result}, 0);
    chk = 1;
    op(15, 5, 0, 20, 0, 0);
    op(63, 1, 0, 64, 0, 0);
    op(30, 10, 1, 20, 0, 0);
    op(0, 1, 1, 4095, 0, 1);
    op(17, 17, 1, 0, 1, 0);
    op(6, 7, 2, 42, 0, 0);
    op(63, 63, 2, 3969, 0, 0);
    op(0, 45, 2, 0, 1, 0);
    op(42, 51, 3, 34, 0, 0);
    // operand changes while idle must not disturb held outputs
    @(negedge clk);
    a = 1; b = 2; sel = 0;
    @(negedge clk);
    check("hold_ov", {31'd0, out_valid}, 0);
    check("hold_res", {20'd0, result}, 34);
    // back-to-back ADD, SUB, MUL, AND on 10 and 3
    a = 10; b = 3; sel = 0; in_valid = 1;
    @(negedge clk);
    check("pipe_add", {20'd0, result}, 13);
    sel = 1;
    @(negedge clk);
    check("pipe_sub", {20'd0, result}, 7);
    sel = 2;
    @(negedge clk);
    check("pipe_mul", {20'd0, result}, 30);
    sel = 3;
    @(negedge clk);
    check("pipe_and", {20'd0, result}, 2);
    check("pipe_and_ov", {31'd0, out_valid}, 1);
    in_valid = 0;
    @(negedge clk);
    check("pipe_end_ov", {31'd0, out_valid}, 0);
    check("pipe_end_res", {20'd0, result}, 2);
    // asynchronous reset mid-cycle with a nonzero held result
    op(5, 9, 2, 45, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_ov", {31'd0, out_valid}, 0);
    check("arst_res", {20'd0, result}, 0);
    check("arst_zero", {31'd0, zero}, 0);
    check("arst_neg", {31'd0, neg}, 0);
    @(negedge clk);
    rst_n = 1;
    op(1, 2, 0, 3, 0, 0);
    op(3, 7, 1, 4092, 0, 1);
    @(negedge clk);
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
